// File: rtl/host_cmd_parser_if.sv
// Host-side bus bundle for the command parser.
// Carries the RX FIFO pop, TX FIFO push and register bus signals.
interface host_cmd_parser_if;
  logic       rx_fifo_rd_en;
  logic [7:0] rx_fifo_dout;
  logic       rx_fifo_empty;
  logic       tx_fifo_wr_en;
  logic [7:0] tx_fifo_wdata;
  logic       tx_fifo_full;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;

  modport master (
    output rx_fifo_rd_en,
    input  rx_fifo_dout,
    input  rx_fifo_empty,
    output tx_fifo_wr_en,
    output tx_fifo_wdata,
    input  tx_fifo_full,
    output reg_addr,
    output reg_wdata,
    output reg_wr,
    output reg_rd,
    input  reg_rdata
  );

  modport slave (
    input  rx_fifo_rd_en,
    output rx_fifo_dout,
    output rx_fifo_empty,
    input  tx_fifo_wr_en,
    input  tx_fifo_wdata,
    output tx_fifo_full,
    input  reg_addr,
    input  reg_wdata,
    input  reg_wr,
    input  reg_rd,
    output reg_rdata
  );
endinterface

// File: rtl/host_cmd_parser.sv
// Framed register read/write packet decoder between the
// host RX/TX FIFOs and the internal 8-bit register bus.
module host_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        host_mode,
  host_cmd_parser_if.master bus,
  output logic              err_csum,
  output logic              err_timeout,
  output logic              busy
);
  localparam logic [7:0] SYNC_REQ = 8'hA5;
  localparam logic [7:0] SYNC_RSP = 8'h5A;
  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;
  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_CSUM  = 8'h01;
  localparam logic [7:0] ST_CMD   = 8'h02;

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_RSP_HDR,
    S_RSP_CMD,
    S_RSP_STAT,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_PUSH
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      csum_q, csum_d;
  logic [7:0]      stat_q, stat_d;
  logic [7:0]      data_q, data_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic [1:0]      mode_q, mode_d;
  logic            run_q, run_d;
  logic            pend_q, pend_d;
  logic [7:0]      reg_addr_q, reg_addr_d;
  logic [7:0]      reg_wdata_q, reg_wdata_d;
  logic            reg_wr_q, reg_wr_d;
  logic            err_csum_q, err_csum_d;
  logic            err_to_q, err_to_d;

  logic       rx_st;
  logic       cnt_st;
  logic       push_st;
  logic       mode_chg;
  logic       cap;
  logic       timeout;
  logic       fetch;
  logic       push_ok;
  logic       csum_bad;
  logic [7:0] rx_b;
  logic [7:0] tx_data;

  assign rx_b   = bus.rx_fifo_dout;
  assign rx_st  = state_q inside
    {S_IDLE, S_CMD, S_ADDR, S_LEN, S_PAYLOAD, S_CSUM};
  assign cnt_st = rx_st && (state_q != S_IDLE);
  assign push_st = state_q inside
    {S_RSP_HDR, S_RSP_CMD, S_RSP_STAT, S_RD_PUSH};

  // run_q masks the first cycle after reset so that a stale
  // mode_q does not look like a host switch
  assign mode_chg = run_q && (host_mode != mode_q);
  assign cap      = pend_q && !mode_chg;
  assign timeout  = cnt_st && !cap && (timer_q == TO_LAST);
  assign fetch    = run_q && rx_st && !pend_q &&
                    !bus.rx_fifo_empty && !mode_chg && !timeout;
  assign push_ok  = push_st && !bus.tx_fifo_full && !mode_chg;
  assign csum_bad = (rx_b != csum_q);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    stat_d      = stat_q;
    data_d      = data_q;
    mode_d      = host_mode;
    run_d       = 1'b1;
    pend_d      = fetch;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    err_csum_d  = 1'b0;
    err_to_d    = 1'b0;
    timer_d     = (cnt_st && !cap) ? timer_q + 1'b1 : '0;

    unique case (state_q)
      S_IDLE: begin
        if (cap && rx_b == SYNC_REQ) state_d = S_CMD;
      end
      S_CMD: begin
        if (cap) begin
          cmd_d   = rx_b;
          csum_d  = rx_b;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cap) begin
          addr_d  = rx_b;
          csum_d  = csum_q ^ rx_b;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (cap) begin
          len_d   = rx_b;
          csum_d  = csum_q ^ rx_b;
          idx_d   = 8'h00;
          state_d = (cmd_q == CMD_WR && rx_b != 8'h00) ?
                    S_PAYLOAD : S_CSUM;
        end
      end
      S_PAYLOAD: begin
        if (cap) begin
          csum_d      = csum_q ^ rx_b;
          reg_wr_d    = 1'b1;
          reg_addr_d  = addr_q + idx_q;
          reg_wdata_d = rx_b;
          idx_d       = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (cap) begin
          err_csum_d = csum_bad;
          idx_d      = 8'h00;
          state_d    = S_RSP_HDR;
          if (csum_bad)
            stat_d = ST_CSUM;
          else if (cmd_q == CMD_WR || cmd_q == CMD_RD)
            stat_d = ST_OK;
          else
            stat_d = ST_CMD;
        end
      end
      S_RSP_HDR: begin
        if (push_ok) state_d = S_RSP_CMD;
      end
      S_RSP_CMD: begin
        if (push_ok) state_d = S_RSP_STAT;
      end
      S_RSP_STAT: begin
        if (push_ok) begin
          if (cmd_q == CMD_RD && stat_q == ST_OK &&
              len_q != 8'h00) begin
            reg_addr_d = addr_q;
            state_d    = S_RD_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        data_d  = bus.reg_rdata;
        state_d = S_RD_PUSH;
      end
      S_RD_PUSH: begin
        if (push_ok) begin
          if (idx_q == len_q - 8'd1) begin
            state_d = S_IDLE;
          end else begin
            idx_d      = idx_q + 8'd1;
            reg_addr_d = addr_q + idx_q + 8'd1;
            state_d    = S_RD_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d  = S_IDLE;
      err_to_d = 1'b1;
      timer_d  = '0;
    end

    // a host switch overrides everything, including a timeout
    if (mode_chg) begin
      state_d  = S_IDLE;
      err_to_d = 1'b0;
      timer_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      stat_q      <= '0;
      data_q      <= '0;
      timer_q     <= '0;
      mode_q      <= '0;
      run_q       <= 1'b0;
      pend_q      <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      err_csum_q  <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      stat_q      <= stat_d;
      data_q      <= data_d;
      timer_q     <= timer_d;
      mode_q      <= mode_d;
      run_q       <= run_d;
      pend_q      <= pend_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      err_csum_q  <= err_csum_d;
      err_to_q    <= err_to_d;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (state_q)
      S_RSP_HDR:  tx_data = SYNC_RSP;
      S_RSP_CMD:  tx_data = cmd_q;
      S_RSP_STAT: tx_data = stat_q;
      S_RD_PUSH:  tx_data = data_q;
      default:    tx_data = 8'h00;
    endcase
  end

  assign bus.rx_fifo_rd_en = fetch;
  assign bus.tx_fifo_wr_en = push_ok;
  assign bus.tx_fifo_wdata = tx_data;
  assign bus.reg_addr      = reg_addr_q;
  assign bus.reg_wdata     = reg_wdata_q;
  assign bus.reg_wr        = reg_wr_q;
  assign bus.reg_rd        = (state_q == S_RD_REQ) && !mode_chg;
  assign err_csum          = err_csum_q;
  assign err_timeout       = err_to_q;
  assign busy              = (state_q != S_IDLE);
endmodule

// File: tb/tb_host_cmd_parser.sv
// Directed bench for host_cmd_parser with FIFO and
// register-bus models and per-scenario inline checks.
module tb_host_cmd_parser;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] host_mode = 2'd0;
  logic       err_csum;
  logic       err_timeout;
  logic       busy;

  host_cmd_parser_if bus();

  host_cmd_parser #(
    .TIMEOUT_CYCLES(16),
    .TO_W(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .host_mode(host_mode),
    .bus(bus),
    .err_csum(err_csum),
    .err_timeout(err_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_mem [256];
  int         rx_wr = 0;
  int         rx_rd = 0;
  int         rd_cyc [256];
  logic [7:0] tx_log [256];
  int         tx_cyc [256];
  int         tx_n = 0;
  logic [7:0] wa [256];
  logic [7:0] wd [256];
  int         wr_cyc [256];
  int         wn = 0;
  logic [7:0] ra [256];
  int         rn = 0;
  int         cyc = 0;
  int         viol = 0;
  int         csum_n = 0;
  int         to_n = 0;
  logic       prev_rd = 1'b0;
  logic       prev_wr = 1'b0;
  logic       prev_rrd = 1'b0;

  assign bus.rx_fifo_empty = (rx_rd == rx_wr);

  // FIFO, register-file and protocol monitor models
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_rd  <= bus.rx_fifo_rd_en;
    prev_wr  <= bus.reg_wr;
    prev_rrd <= bus.reg_rd;
    if (bus.rx_fifo_rd_en) begin
      if (bus.rx_fifo_empty || prev_rd) viol <= viol + 1;
      bus.rx_fifo_dout <= rx_mem[rx_rd];
      rd_cyc[rx_rd]    <= cyc;
      rx_rd            <= rx_rd + 1;
    end
    if (bus.tx_fifo_wr_en) begin
      if (bus.tx_fifo_full) viol <= viol + 1;
      tx_log[tx_n] <= bus.tx_fifo_wdata;
      tx_cyc[tx_n] <= cyc;
      tx_n         <= tx_n + 1;
    end
    if (bus.reg_wr) begin
      if (prev_wr) viol <= viol + 1;
      wa[wn]     <= bus.reg_addr;
      wd[wn]     <= bus.reg_wdata;
      wr_cyc[wn] <= cyc;
      wn         <= wn + 1;
    end
    if (bus.reg_rd) begin
      if (prev_rrd) viol <= viol + 1;
      bus.reg_rdata <= bus.reg_addr ^ 8'hFF;
      ra[rn]        <= bus.reg_addr;
      rn            <= rn + 1;
    end
    if (err_csum) csum_n <= csum_n + 1;
    if (err_timeout) to_n <= to_n + 1;
  end

  task automatic send(input logic [95:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      rx_mem[rx_wr] = v[8*(n-1-i) +: 8];
      rx_wr = rx_wr + 1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (!(rx_rd == rx_wr && !busy) && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 500) begin
      errors++;
      $display("FAIL %s idle_wait got busy=%0b need 0", tag, busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %0b need 0", busy);
    end
    checks++;
    if ({bus.rx_fifo_rd_en, bus.tx_fifo_wr_en, bus.reg_wr,
         bus.reg_rd, err_csum, err_timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b need 000000",
        {bus.rx_fifo_rd_en, bus.tx_fifo_wr_en, bus.reg_wr,
         bus.reg_rd, err_csum, err_timeout});
    end
    checks++;
    if ({bus.reg_addr, bus.reg_wdata, bus.tx_fifo_wdata}
        !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got %h need 000000",
        {bus.reg_addr, bus.reg_wdata, bus.tx_fifo_wdata});
    end
  endtask

  task automatic test_write();
    int tb, wb, rb, cb;
    logic [7:0] e [3];
    e = '{8'h5A, 8'h01, 8'h00};
    tb = tx_n; wb = wn; rb = rx_wr; cb = csum_n;
    send(96'hA5_01_10_02_AA_BB_02, 7);
    wait_idle("write");
    checks++;
    if (tx_n - tb !== 3) begin
      errors++;
      $display("FAIL write_tx_count got %0d need 3", tx_n - tb);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_log[tb+i] !== e[i]) begin
        errors++;
        $display("FAIL write_tx[%0d] got %h need %h",
          i, tx_log[tb+i], e[i]);
      end
    end
    checks++;
    if (wn - wb !== 2 || wa[wb] !== 8'h10 || wd[wb] !== 8'hAA ||
        wa[wb+1] !== 8'h11 || wd[wb+1] !== 8'hBB) begin
      errors++;
      $display("FAIL write_regs got n=%0d %h/%h %h/%h need 2 10/aa 11/bb",
        wn - wb, wa[wb], wd[wb], wa[wb+1], wd[wb+1]);
    end
    checks++;
    if (wr_cyc[wb] - rd_cyc[rb+4] !== 2) begin
      errors++;
      $display("FAIL write_wr_latency got %0d need 2",
        wr_cyc[wb] - rd_cyc[rb+4]);
    end
    checks++;
    if (tx_cyc[tb] - rd_cyc[rb+6] !== 2) begin
      errors++;
      $display("FAIL write_rsp_latency got %0d need 2",
        tx_cyc[tb] - rd_cyc[rb+6]);
    end
    checks++;
    if (csum_n - cb !== 0) begin
      errors++;
      $display("FAIL write_err_csum got %0d need 0", csum_n - cb);
    end
  endtask

  task automatic test_read();
    int tb, wb, rb;
    logic [7:0] e [6];
    logic [7:0] a [3];
    e = '{8'h5A, 8'h02, 8'h00, 8'h01, 8'h00, 8'hFF};
    a = '{8'hFE, 8'hFF, 8'h00};
    tb = tx_n; wb = wn; rb = rn;
    send(96'hA5_02_FE_03_FF, 5);
    wait_idle("read");
    checks++;
    if (tx_n - tb !== 6) begin
      errors++;
      $display("FAIL read_tx_count got %0d need 6", tx_n - tb);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (tx_log[tb+i] !== e[i]) begin
        errors++;
        $display("FAIL read_tx[%0d] got %h need %h",
          i, tx_log[tb+i], e[i]);
      end
    end
    checks++;
    if (rn - rb !== 3) begin
      errors++;
      $display("FAIL read_rd_count got %0d need 3", rn - rb);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ra[rb+i] !== a[i]) begin
        errors++;
        $display("FAIL read_addr[%0d] got %h need %h",
          i, ra[rb+i], a[i]);
      end
    end
    checks++;
    if (tx_cyc[tb+4] - tx_cyc[tb+3] !== 3) begin
      errors++;
      $display("FAIL read_turnaround got %0d need 3",
        tx_cyc[tb+4] - tx_cyc[tb+3]);
    end
    checks++;
    if (wn - wb !== 0) begin
      errors++;
      $display("FAIL read_no_writes got %0d need 0", wn - wb);
    end
  endtask

  task automatic test_bad_csum();
    int tb, wb, cb;
    logic [7:0] e [3];
    e = '{8'h5A, 8'h01, 8'h01};
    tb = tx_n; wb = wn; cb = csum_n;
    send(96'hA5_01_20_01_55_00, 6);
    wait_idle("bad_csum");
    checks++;
    if (wn - wb !== 1 || wa[wb] !== 8'h20 || wd[wb] !== 8'h55) begin
      errors++;
      $display("FAIL csum_write got n=%0d %h/%h need 1 20/55",
        wn - wb, wa[wb], wd[wb]);
    end
    checks++;
    if (csum_n - cb !== 1) begin
      errors++;
      $display("FAIL csum_pulse got %0d need 1", csum_n - cb);
    end
    checks++;
    if (tx_n - tb !== 3) begin
      errors++;
      $display("FAIL csum_tx_count got %0d need 3", tx_n - tb);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_log[tb+i] !== e[i]) begin
        errors++;
        $display("FAIL csum_tx[%0d] got %h need %h",
          i, tx_log[tb+i], e[i]);
      end
    end
  endtask

  task automatic test_bad_cmd();
    int tb, wb, rb;
    logic [7:0] e [3];
    e = '{8'h5A, 8'h07, 8'h02};
    tb = tx_n; wb = wn; rb = rn;
    send(96'h00_37_A5_07_00_00_07, 7);
    wait_idle("bad_cmd");
    checks++;
    if (tx_n - tb !== 3) begin
      errors++;
      $display("FAIL cmd_tx_count got %0d need 3", tx_n - tb);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_log[tb+i] !== e[i]) begin
        errors++;
        $display("FAIL cmd_tx[%0d] got %h need %h",
          i, tx_log[tb+i], e[i]);
      end
    end
    checks++;
    if (wn - wb !== 0 || rn - rb !== 0) begin
      errors++;
      $display("FAIL cmd_bus got wr=%0d rd=%0d need 0 0",
        wn - wb, rn - rb);
    end
  endtask

  task automatic test_timeout();
    int tb, wb, ob;
    logic [7:0] e [3];
    e = '{8'h5A, 8'h01, 8'h00};
    tb = tx_n; ob = to_n;
    send(96'hA5_01, 2);
    repeat (40) @(negedge clk);
    checks++;
    if (to_n - ob !== 1) begin
      errors++;
      $display("FAIL to_pulse got %0d need 1", to_n - ob);
    end
    checks++;
    if (tx_n - tb !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_abort got tx=%0d busy=%0b need 0 0",
        tx_n - tb, busy);
    end
    tb = tx_n; wb = wn;
    send(96'hA5_01_30_01_77_47, 6);
    wait_idle("timeout_next");
    checks++;
    if (wn - wb !== 1 || wa[wb] !== 8'h30 || wd[wb] !== 8'h77) begin
      errors++;
      $display("FAIL to_next_write got n=%0d %h/%h need 1 30/77",
        wn - wb, wa[wb], wd[wb]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_log[tb+i] !== e[i] || tx_n - tb !== 3) begin
        errors++;
        $display("FAIL to_next_tx[%0d] got %h n=%0d need %h n=3",
          i, tx_log[tb+i], tx_n - tb, e[i]);
      end
    end
    checks++;
    if (to_n - ob !== 1) begin
      errors++;
      $display("FAIL to_spurious got %0d need 1", to_n - ob);
    end
  endtask

  task automatic test_tx_full();
    int tb;
    logic [7:0] e [5];
    e = '{8'h5A, 8'h02, 8'h00, 8'hBF, 8'hBE};
    tb = tx_n;
    bus.tx_fifo_full = 1'b1;
    send(96'hA5_02_40_02_40, 5);
    repeat (40) @(negedge clk);
    checks++;
    if (tx_n - tb !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL full_hold got tx=%0d busy=%0b need 0 1",
        tx_n - tb, busy);
    end
    bus.tx_fifo_full = 1'b0;
    wait_idle("tx_full");
    checks++;
    if (tx_n - tb !== 5) begin
      errors++;
      $display("FAIL full_tx_count got %0d need 5", tx_n - tb);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_log[tb+i] !== e[i]) begin
        errors++;
        $display("FAIL full_tx[%0d] got %h need %h",
          i, tx_log[tb+i], e[i]);
      end
    end
  endtask

  task automatic test_mode_abort();
    int tb, rb;
    tb = tx_n; rb = rn;
    bus.tx_fifo_full = 1'b1;
    send(96'hA5_02_40_02_40, 5);
    repeat (30) @(negedge clk);
    bus.tx_fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    bus.tx_fifo_full = 1'b1;
    host_mode = 2'd1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mode_idle got busy=%0b need 0", busy);
    end
    bus.tx_fifo_full = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (tx_n - tb !== 2 || tx_log[tb] !== 8'h5A ||
        tx_log[tb+1] !== 8'h02) begin
      errors++;
      $display("FAIL mode_tx got n=%0d %h %h need 2 5a 02",
        tx_n - tb, tx_log[tb], tx_log[tb+1]);
    end
    checks++;
    if (rn - rb !== 0) begin
      errors++;
      $display("FAIL mode_reads got %0d need 0", rn - rb);
    end
  endtask

  task automatic test_back_to_back();
    int tb, wb, rb;
    logic [7:0] e [7];
    e = '{8'h5A, 8'h01, 8'h00, 8'h5A, 8'h02, 8'h00, 8'hAF};
    tb = tx_n; wb = wn; rb = rn;
    send(96'hA5_01_50_01_11_41, 6);
    send(96'hA5_02_50_01_53, 5);
    wait_idle("b2b");
    checks++;
    if (tx_n - tb !== 7) begin
      errors++;
      $display("FAIL b2b_tx_count got %0d need 7", tx_n - tb);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (tx_log[tb+i] !== e[i]) begin
        errors++;
        $display("FAIL b2b_tx[%0d] got %h need %h",
          i, tx_log[tb+i], e[i]);
      end
    end
    checks++;
    if (wn - wb !== 1 || wa[wb] !== 8'h50 || wd[wb] !== 8'h11 ||
        rn - rb !== 1 || ra[rb] !== 8'h50) begin
      errors++;
      $display("FAIL b2b_bus got w=%0d %h/%h r=%0d %h",
        wn - wb, wa[wb], wd[wb], rn - rb, ra[rb]);
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL protocol_violations got %0d need 0", viol);
    end
  endtask

  task automatic test_async_reset();
    int tb, wb;
    send(96'hA5_01_60_03, 4);
    repeat (12) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got busy=%0b need 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, bus.rx_fifo_rd_en, bus.tx_fifo_wr_en, bus.reg_wr,
         bus.reg_rd, err_csum, err_timeout} !== 7'b0 ||
        bus.reg_addr !== 8'h00) begin
      errors++;
      $display("FAIL arst_outputs got %b addr %h need 0 00",
        {busy, bus.rx_fifo_rd_en, bus.tx_fifo_wr_en, bus.reg_wr,
         bus.reg_rd, err_csum, err_timeout}, bus.reg_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tb = tx_n; wb = wn;
    send(96'hA5_01_70_01_99_E9, 6);
    wait_idle("arst_next");
    checks++;
    if (wn - wb !== 1 || wa[wb] !== 8'h70 || wd[wb] !== 8'h99 ||
        tx_n - tb !== 3 || tx_log[tb+2] !== 8'h00) begin
      errors++;
      $display("FAIL arst_next got w=%0d %h/%h tx=%0d st=%h",
        wn - wb, wa[wb], wd[wb], tx_n - tb, tx_log[tb+2]);
    end
  endtask

  initial begin
    bus.tx_fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_bad_csum();
    test_bad_cmd();
    test_timeout();
    test_tx_full();
    test_mode_abort();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
